// File: rtl/iir_zero_mac.sv
// Second-order FIR (zero) section: three taps through one shared 12x12 signed multiplier.
// One sample is accepted in IDLE and the sum is produced three clock edges later.
module iir_zero_mac #(
  parameter logic signed [11:0] B0 = 12'sd25,
  parameter logic signed [11:0] B1 = 12'sd50,
  parameter logic signed [11:0] B2 = 12'sd25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        flush,
  output logic [24:0] dout,
  output logic        dout_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC0 = 2'd1,
    MAC1 = 2'd2,
    MAC2 = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic signed [11:0] x0_r;
  logic signed [11:0] x1_r;
  logic signed [11:0] x2_r;
  logic signed [24:0] acc_r;
  logic signed [11:0] coef_s;
  logic signed [11:0] samp_s;
  logic signed [23:0] prod_s;
  logic signed [24:0] sum_s;

  // Select the tap/sample pair for the shared multiplier and accumulate.
  always_comb begin
    coef_s = B0;
    samp_s = x0_r;
    case (state_r)
      MAC0: begin
        coef_s = B0;
        samp_s = x0_r;
      end
      MAC1: begin
        coef_s = B1;
        samp_s = x1_r;
      end
      MAC2: begin
        coef_s = B2;
        samp_s = x2_r;
      end
      default: begin
        coef_s = B0;
        samp_s = x0_r;
      end
    endcase
    prod_s = coef_s * samp_s;
    sum_s  = acc_r + $signed({prod_s[23], prod_s});
  end

  // Ready only in IDLE and never while reset is held.
  always_comb begin
    din_ready = (state_r == IDLE) && !rst_n;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (din_valid) begin
            state_nxt_s = MAC0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MAC0:    state_nxt_s = MAC1;
        MAC1:    state_nxt_s = MAC2;
        MAC2:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register; reset polarity is active-high despite the rst_n name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Delay line, accumulator and result registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x0_r       <= 12'sd0;
      x1_r       <= 12'sd0;
      x2_r       <= 12'sd0;
      acc_r      <= 25'sd0;
      dout       <= 25'd0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      x0_r       <= 12'sd0;
      x1_r       <= 12'sd0;
      x2_r       <= 12'sd0;
      acc_r      <= 25'sd0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (din_valid) begin
            x2_r  <= x1_r;
            x1_r  <= x0_r;
            x0_r  <= $signed(din);
            acc_r <= 25'sd0;
          end else begin
            acc_r <= acc_r;
          end
        end
        MAC0: acc_r <= sum_s;
        MAC1: acc_r <= sum_s;
        MAC2: begin
          dout       <= sum_s;
          dout_valid <= 1'b1;
        end
        default: acc_r <= acc_r;
      endcase
    end
  end

endmodule

// File: doc/iir_zero_mac.md
IIR_ZERO_MAC -- requirements
Module: iir_zero_mac

Interface
REQ-001 SHALL have parameter B0, default 12'sd25, feed-forward tap applied to x[n] (signed Q10).
REQ-002 SHALL have parameter B1, default 12'sd50, feed-forward tap applied to x[n-1] (signed Q10).
REQ-003 SHALL have parameter B2, default 12'sd25, feed-forward tap applied to x[n-2] (signed Q10).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-high (asserted when 1).
REQ-006 SHALL have port din  input  12  signed input sample x[n].
REQ-007 SHALL have port din_valid  input  1  din qualifier.
REQ-008 SHALL have port din_ready  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port flush  input  1  synchronous clear of delay line and abort of the current computation.
REQ-010 SHALL have port dout  output  25  signed feed-forward sum, same Q scaling and width as the pole-section sum it is combined with.
REQ-011 SHALL have port dout_valid  output  1  one-cycle strobe marking a new dout.

Function
REQ-012 SHALL compute dout = B0*x[n] + B1*x[n-1] + B2*x[n-2] using one shared 12x12 signed multiplier and a 25-bit signed accumulator.
REQ-013 SHALL keep 12x12 products at 24 bits, sign-extended to 25 bits before accumulation; no overflow is possible (|sum| <= 3*2^22 < 2^24), so no saturation and no rescaling are applied.
REQ-014 SHALL implement FSM states IDLE, MAC0, MAC1, MAC2.
REQ-015 SHALL drive din_ready = 1 only in IDLE, combinationally from state.
REQ-016 SHALL accept a sample at an edge where state = IDLE and din_valid = 1 and flush = 0: x2<=x1, x1<=x0, x0<=din, acc<=0, state->MAC0.
REQ-017 SHALL ignore din_valid while din_ready = 0; delay line unchanged; upstream holds the sample.
REQ-018 SHALL, in MAC0, add B0*x0 to acc at the next edge, state->MAC1.
REQ-019 SHALL, in MAC1, add B1*x1 to acc at the next edge, state->MAC2.
REQ-020 SHALL, in MAC2, at the next edge: dout <= acc + B2*x2, dout_valid <= 1, state->IDLE.
REQ-021 SHALL hold dout_valid high for exactly one cycle; dout holds its value until the next result.
REQ-022 SHALL have latency: accepted at edge E0 -> dout/dout_valid updated at edge E3; max throughput one sample per 4 clocks.
REQ-023 SHALL, on flush = 1 at any edge: x0,x1,x2,acc <= 0, state->IDLE, dout_valid <= 0, dout unchanged; a concurrent din_valid is not accepted (flush wins).
REQ-024 SHALL start from x[n-1] = x[n-2] = 0 after reset or flush, i.e. zero initial conditions.

Reset
REQ-025 SHALL, while rst_n = 1, asynchronously force state = IDLE, x0 = x1 = x2 = 0, acc = 0, dout = 0, dout_valid = 0.
REQ-026 SHALL drive din_ready = 0 while rst_n = 1; din_ready = 1 from the first cycle after release.
REQ-027 SHALL, when reset is asserted mid-computation (MAC0..MAC2), produce no dout_valid for the aborted sample.

Verification
REQ-028 SHALL verify impulse din = 1024 followed by zeros, each accepted when ready -> dout = 25600, 51200, 25600, 0, 0.
REQ-029 SHALL verify constant din = 100 for 4 samples -> dout = 2500, 7500, 10000, 10000.
REQ-030 SHALL verify extremes: din = -2048 x3 -> dout = -51200, -153600, -204800; din = 2047 x3 -> final dout = 204700.
REQ-031 SHALL verify back-pressure: din_valid held high continuously -> din_ready high 1 of every 4 cycles, E0 to dout_valid exactly 3 edges, no sample skipped or duplicated.
REQ-032 SHALL verify flush: flush asserted in MAC1 after x history {1024,1024} -> no dout_valid, din_ready next cycle, next din = 1024 yields dout = 25600.
REQ-033 SHALL verify reset: rst_n asserted in MAC2 -> dout = 0, dout_valid = 0 immediately, asynchronously without a clock edge; after release, first sample computes with zero history.
